bin_to_seven_seg_display: RTL and testbench

Sequential binary-to-decimal seven-segment display driver that generalises the fixed 5-bit, two-digit decoder to any input width and digit count. It converts an unsigned binary value to BCD with an iterative shift-and-add-3 (double-dabble) engine, one bit per clock. It then drives DIGITS active-low seven-segment codes with optional leading-zero blanking and an overflow indication. It sits between datapath result registers (e.g. a GCD output) and the board HEX displays.

---
 rtl/bin_to_seven_seg_display.sv | 132 +++++++++++++
 tb/tb_bin_to_seven_seg_display.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_seven_seg_display.sv
// Binary to multi-digit seven-segment driver: iterative double-dabble conversion,
// one input bit per clock, with leading-zero blanking and overflow indication.
module bin_to_seven_seg_display #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    input  logic                  blank_lz,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [8*DIGITS-1:0]   disp
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);
    localparam logic [7:0] SEG_BLANK = 8'b11111111;
    localparam logic [7:0] SEG_OVF   = 8'b01111111;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] LIMIT = pow10(DIGITS);

    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'b11000000;
            4'd1:    seg_decode = 8'b11111001;
            4'd2:    seg_decode = 8'b10100100;
            4'd3:    seg_decode = 8'b10110000;
            4'd4:    seg_decode = 8'b10011001;
            4'd5:    seg_decode = 8'b10010010;
            4'd6:    seg_decode = 8'b10000010;
            4'd7:    seg_decode = 8'b11111000;
            4'd8:    seg_decode = 8'b10000000;
            4'd9:    seg_decode = 8'b10010000;
            default: seg_decode = SEG_OVF;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    shreg;
    logic [BCD_W-1:0]    bcd;
    logic [BCD_W-1:0]    bcd_adj;
    logic                blank_q;
    logic                ovf_pend;
    logic                accept;
    logic                lead;
    logic [8*DIGITS-1:0] disp_next;

    assign accept = (state == IDLE) && start;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Blanking walks down from the top digit until the first nonzero digit.
    always_comb begin
        disp_next = '1;
        lead      = blank_q;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (lead && (i != 0) && (bcd[4*i +: 4] == 4'd0)) begin
                disp_next[8*i +: 8] = SEG_BLANK;
            end else begin
                disp_next[8*i +: 8] = seg_decode(bcd[4*i +: 4]);
                lead = 1'b0;
            end
        end
    end

    // Conversion datapath: holds no control meaning, so it is not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg    <= bin_in;
            bcd      <= '0;
            blank_q  <= blank_lz;
            ovf_pend <= (64'(bin_in) >= LIMIT);
        end else if (state == SHIFT) begin
            shreg <= shreg << 1;
            bcd   <= {bcd_adj[BCD_W-2:0], shreg[WIDTH-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            disp     <= '1;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) state <= LATCH;
                end
                LATCH: begin
                    disp     <= ovf_pend ? {DIGITS{SEG_OVF}} : disp_next;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_seven_seg_display.sv
// Scoreboard bench for bin_to_seven_seg_display: 3-digit and 2-digit instances,
// expected codes queued at issue time and checked whenever done pulses.
module tb_bin_to_seven_seg_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start3 = 1'b0;
    logic        start2 = 1'b0;
    logic [7:0]  bin = 8'd0;
    logic        blz = 1'b0;
    logic        busy3, done3, ovf3;
    logic [23:0] disp3;
    logic        busy2, done2, ovf2;
    logic [15:0] disp2;

    typedef struct packed {
        logic [23:0] disp;
        logic        ovf;
    } exp_t;

    exp_t q3[$];
    exp_t q2[$];
    int   checks   = 0;
    int   failures = 0;
    int   ndone3   = 0;

    always #5 clk = ~clk;

    bin_to_seven_seg_display #(.WIDTH(8), .DIGITS(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .bin_in(bin), .blank_lz(blz),
        .busy(busy3), .done(done3), .overflow(ovf3), .disp(disp3)
    );

    bin_to_seven_seg_display #(.WIDTH(8), .DIGITS(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .bin_in(bin), .blank_lz(blz),
        .busy(busy2), .done(done2), .overflow(ovf2), .disp(disp2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per done pulse.
    always @(negedge clk) begin
        if (done3) begin
            ndone3++;
            if (q3.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d3_unexpected_done actual=%0h expected=none", disp3);
            end else begin
                exp_t e;
                e = q3.pop_front();
                check("d3_disp", 64'(disp3), 64'(e.disp));
                check("d3_ovf", 64'(ovf3), 64'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (done2) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL d2_unexpected_done actual=%0h expected=none", disp2);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("d2_disp", 64'(disp2), 64'(e.disp));
                check("d2_ovf", 64'(ovf2), 64'(e.ovf));
            end
        end
    end

    task automatic run3(input logic [7:0] v, input logic b, input logic [23:0] ed,
                        input logic eo, input logic ign);
        int k;
        int busy_cnt;
        exp_t e;
        k = 0;
        while (busy3 && k < 50) begin @(posedge clk); #1; k++; end
        bin = v; blz = b; start3 = 1'b1;
        @(posedge clk);
        e.disp = ed; e.ovf = eo;
        q3.push_back(e);
        #1 start3 = 1'b0;
        busy_cnt = busy3 ? 1 : 0;
        for (k = 1; k <= 20; k++) begin
            if (ign && (k == 3 || k == 5)) begin
                start3 = 1'b1; bin = 8'd200;
            end else begin
                start3 = 1'b0;
            end
            @(posedge clk); #1;
            if (done3) break;
            if (busy3) busy_cnt++;
        end
        start3 = 1'b0;
        check("d3_done_latency", 64'(k), 64'd9);
        check("d3_busy_cycles", 64'(busy_cnt), 64'd9);
        check("d3_busy_clear", 64'(busy3), 64'd0);
        @(posedge clk); #1;
        check("d3_done_width", 64'(done3), 64'd0);
    endtask

    task automatic run2(input logic [7:0] v, input logic b, input logic [15:0] ed, input logic eo);
        int k;
        exp_t e;
        k = 0;
        while (busy2 && k < 50) begin @(posedge clk); #1; k++; end
        bin = v; blz = b; start2 = 1'b1;
        @(posedge clk);
        e.disp = 24'(ed); e.ovf = eo;
        q2.push_back(e);
        #1 start2 = 1'b0;
        for (k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done2) break;
        end
        check("d2_done_latency", 64'(k), 64'd9);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int nd;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy3), 64'd0);
        check("rst_done", 64'(done3), 64'd0);
        check("rst_ovf", 64'(ovf3), 64'd0);
        check("rst_disp3", 64'(disp3), 64'hFFFFFF);
        check("rst_disp2", 64'(disp2), 64'hFFFF);
        rst = 1'b0;
        @(posedge clk); #1;

        run3(8'd255, 1'b0, 24'hA49292, 1'b0, 1'b0);
        run3(8'd7,   1'b1, 24'hFFFFF8, 1'b0, 1'b0);
        run3(8'd7,   1'b0, 24'hC0C0F8, 1'b0, 1'b0);
        run3(8'd0,   1'b1, 24'hFFFFC0, 1'b0, 1'b0);
        run3(8'd100, 1'b1, 24'hF9C0C0, 1'b0, 1'b0);
        run3(8'd40,  1'b1, 24'hFF99C0, 1'b0, 1'b0);

        run2(8'd100, 1'b0, 16'h7F7F, 1'b1);
        run2(8'd99,  1'b0, 16'h9090, 1'b0);
        run2(8'd255, 1'b1, 16'h7F7F, 1'b1);
        run2(8'd10,  1'b1, 16'hF9C0, 1'b0);
        run2(8'd5,   1'b1, 16'hFF92, 1'b0);

        nd = ndone3;
        run3(8'd123, 1'b0, 24'hF9A4B0, 1'b0, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        check("ign_single_done", 64'(ndone3 - nd), 64'd1);

        // Abort a conversion mid-flight.
        bin = 8'd77; blz = 1'b0; start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy3), 64'd0);
        check("abort_done", 64'(done3), 64'd0);
        check("abort_ovf", 64'(ovf3), 64'd0);
        check("abort_disp", 64'(disp3), 64'hFFFFFF);
        @(posedge clk); #1 rst = 1'b0;
        nd = ndone3;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_done", 64'(ndone3 - nd), 64'd0);

        run3(8'd42, 1'b0, 24'hC099A4, 1'b0, 1'b0);

        check("q3_drained", 64'(q3.size()), 64'd0);
        check("q2_drained", 64'(q2.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
